// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM bus arbiter.
// Lock feature is enabled by defining ARB_LOCK_EN.
package ram_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT
  } arb_state_t;

  // Index after i, wrapping at n.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/ram_bus_if.sv
// Requester-side and RAM-side bus bundle.
// req_lock exists only when ARB_LOCK_EN is defined.
interface ram_bus_if #(
  parameter int NREQ = 4
);
  import ram_arb_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_rwn;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]        req_lock;
`endif
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rvalid;
  logic [DATA_W-1:0]      rdata;
  logic                   mem_en;
  logic                   mem_rwn;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  req,
    input  req_rwn,
    input  req_addr,
    input  req_wdata,
`ifdef ARB_LOCK_EN
    input  req_lock,
`endif
    output gnt,
    output rvalid,
    output rdata,
    output mem_en,
    output mem_rwn,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req,
    output req_rwn,
    output req_addr,
    output req_wdata,
`ifdef ARB_LOCK_EN
    output req_lock,
`endif
    input  gnt,
    input  rvalid,
    input  rdata,
    input  mem_en,
    input  mem_rwn,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/ram_bus_arbiter_rr_pick.sv
// Round-robin picker: first request at or above ptr,
// wrapping modulo NREQ. Purely combinational.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            any
);

  int idx;

  // Scan upward from ptr, keep the first hit.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        win[idx] = 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing one sync RAM bus.
// Optional bus locking via ARB_LOCK_EN.
module ram_bus_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 4
`ifdef ARB_LOCK_EN
  ,
  parameter int MAX_LOCK = 4
`endif
) (
  input logic      clk,
  input logic      rst,
  ram_bus_if.slave bus
);

  localparam int PW = $clog2(NREQ);

  arb_state_t        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   win_q, win_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rwn_q, mem_rwn_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NREQ-1:0]   arb_req;
  logic [NREQ-1:0]   pick_win;
  logic              pick_any;

`ifdef ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic          lock_on_q, lock_on_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_hit;
  logic          fire;
  logic          done;

  // Lock only holds while its owner keeps requesting.
  assign lock_hit = lock_on_q & |(bus.req & win_q);
  assign arb_req  = lock_hit ? (bus.req & win_q) : bus.req;
  assign fire     = (state_q == IDLE) & pick_any;
  assign done     = (state_q == RDWAIT)
                  | ((state_q == ISSUE) & ~mem_rwn_q);

  // Lock tracking: grant count and release/force-off.
  always_comb begin
    lock_on_d  = lock_on_q;
    lock_cnt_d = lock_cnt_q;
    if (state_q == IDLE && lock_on_q && !lock_hit) begin
      lock_on_d  = 1'b0;
      lock_cnt_d = '0;
    end
    if (fire) begin
      lock_cnt_d = lock_hit ? lock_cnt_q + CW'(1)
                            : CW'(1);
    end
    if (done) begin
      if (|(bus.req_lock & win_q) &&
          lock_cnt_q < CW'(MAX_LOCK)) begin
        lock_on_d = 1'b1;
      end else begin
        lock_on_d  = 1'b0;
        lock_cnt_d = '0;
      end
    end
  end

  // Lock state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_on_q  <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      lock_on_q  <= lock_on_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  assign arb_req = bus.req;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req  (arb_req),
    .ptr  (ptr_q),
    .win  (pick_win),
    .any  (pick_any)
  );

  // Next state, grant and RAM drive.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    mem_en_d    = 1'b0;
    mem_rwn_d   = mem_rwn_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = ISSUE;
          win_d    = pick_win;
          gnt_d    = pick_win;
          mem_en_d = 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            if (pick_win[i]) begin
              mem_rwn_d   = bus.req_rwn[i];
              mem_addr_d  =
                bus.req_addr[i*ADDR_W +: ADDR_W];
              mem_wdata_d =
                bus.req_wdata[i*DATA_W +: DATA_W];
              ptr_d       = PW'(wrap_inc(i, NREQ));
            end
          end
        end
      end
      ISSUE: begin
        state_d = mem_rwn_q ? RDWAIT : IDLE;
      end
      RDWAIT: begin
        state_d  = IDLE;
        rvalid_d = win_q;
        rdata_d  = bus.mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // Main registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_rwn_q   <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_en_q    <= mem_en_d;
      mem_rwn_q   <= mem_rwn_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_rwn   = mem_rwn_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter with a RAM model.
// Lock scenario runs only when ARB_LOCK_EN is defined.
module tb_ram_bus_arbiter;
  import ram_arb_pkg::*;

  typedef struct {
    int         cyc;
    logic [3:0] oh;
    logic       rwn;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t gq[$];
  exp_t rq[$];
  logic [7:0] ram [256];

  ram_bus_if #(.NREQ(4)) bus ();

  ram_bus_arbiter #(
    .NREQ (4)
`ifdef ARB_LOCK_EN
    ,
    .MAX_LOCK (4)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (!bus.mem_rwn) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_g(input int c, input int r,
                        input logic rwn,
                        input logic [7:0] a,
                        input logic [7:0] d);
    exp_t e;
    e.cyc = c;
    e.oh = 4'(1 << r);
    e.rwn = rwn;
    e.addr = a;
    e.data = d;
    gq.push_back(e);
  endtask

  task automatic push_r(input int c, input int r,
                        input logic [7:0] d);
    exp_t e;
    e.cyc = c;
    e.oh = 4'(1 << r);
    e.rwn = 1'b1;
    e.addr = 8'h00;
    e.data = d;
    rq.push_back(e);
  endtask

  task automatic set_req(input int i, input logic rwn,
                         input logic [7:0] a,
                         input logic [7:0] d);
    bus.req[i] = 1'b1;
    bus.req_rwn[i] = rwn;
    bus.req_addr[i*8 +: 8] = a;
    bus.req_wdata[i*8 +: 8] = d;
  endtask

  // Monitor: compare every grant/read return to the queues.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (gq.size() > 0 && gq[0].cyc < cyc) begin
        e = gq.pop_front();
        check("gnt_missed", 64'(cyc), 64'(e.cyc));
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        e = rq.pop_front();
        check("rvalid_missed", 64'(cyc), 64'(e.cyc));
      end
      if (bus.gnt != 4'b0) begin
        if (gq.size() == 0) begin
          check("gnt_unexpected", 64'(bus.gnt), 64'(0));
        end else begin
          e = gq.pop_front();
          check("gnt",
            {26'(0), 16'(cyc), bus.gnt, bus.mem_en,
             bus.mem_rwn, bus.mem_addr, bus.mem_wdata},
            {26'(0), 16'(e.cyc), e.oh, 1'b1,
             e.rwn, e.addr, e.data});
        end
      end
      if (bus.rvalid != 4'b0) begin
        if (rq.size() == 0) begin
          check("rvalid_unexpected", 64'(bus.rvalid),
                64'(0));
        end else begin
          e = rq.pop_front();
          check("rvalid",
            {36'(0), 16'(cyc), bus.rvalid, bus.rdata},
            {36'(0), 16'(e.cyc), e.oh, e.data});
        end
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    bus.req = '0;
    bus.req_rwn = '1;
    bus.req_addr = '0;
    bus.req_wdata = '0;
`ifdef ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    tick(3);
    check("rst_gnt", 64'(bus.gnt), 64'(0));
    check("rst_rvalid", 64'(bus.rvalid), 64'(0));
    check("rst_mem_en", 64'(bus.mem_en), 64'(0));
    check("rst_mem_rwn", 64'(bus.mem_rwn), 64'(1));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
    check("rst_rdata", 64'(bus.rdata), 64'(0));
    rst = 1'b0;

    // Single write by requester 1.
    t = cyc;
    set_req(1, 1'b0, 8'h10, 8'h5A);
    push_g(t + 1, 1, 1'b0, 8'h10, 8'h5A);
    tick(2);
    bus.req[1] = 1'b0;
    tick(1);

    // Read-back by requester 2.
    t = cyc;
    set_req(2, 1'b1, 8'h10, 8'h00);
    push_g(t + 1, 2, 1'b1, 8'h10, 8'h00);
    push_r(t + 3, 2, 8'h5A);
    tick(2);
    bus.req[2] = 1'b0;
    tick(2);

    // Wrap and skip: ptr is 3, req = 0101.
    t = cyc;
    set_req(0, 1'b0, 8'h30, 8'h11);
    set_req(2, 1'b0, 8'h32, 8'h22);
    push_g(t + 1, 0, 1'b0, 8'h30, 8'h11);
    push_g(t + 3, 2, 1'b0, 8'h32, 8'h22);
    tick(2);
    bus.req[0] = 1'b0;
    tick(2);
    bus.req[2] = 1'b0;
    tick(1);

    // Reset while a read sits in RDWAIT.
    t = cyc;
    set_req(3, 1'b1, 8'h30, 8'h00);
    push_g(t + 1, 3, 1'b1, 8'h30, 8'h00);
    tick(2);
    rst = 1'b1;
    bus.req[3] = 1'b0;
    tick(1);
    check("rdw_rvalid", 64'(bus.rvalid), 64'(0));
    check("rdw_gnt", 64'(bus.gnt), 64'(0));
    check("rdw_mem_en", 64'(bus.mem_en), 64'(0));
    check("rdw_state", 64'(dut.state_q), 64'(IDLE));
    check("rdw_ptr", 64'(dut.ptr_q), 64'(0));
    rst = 1'b0;
    tick(2);

    // Contention: all four writing, order 0,1,2,3,0.
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b0, 8'(8'h40 + i), 8'(8'hB0 + i));
      push_g(t + 1 + 2*i, i, 1'b0,
             8'(8'h40 + i), 8'(8'hB0 + i));
    end
    push_g(t + 9, 0, 1'b0, 8'h40, 8'hB0);
    tick(10);
    bus.req = '0;
    tick(2);

`ifdef ARB_LOCK_EN
    // Lock: four grants to 1, then requester 0.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    t = cyc;
    set_req(1, 1'b0, 8'h50, 8'hC1);
    bus.req_lock[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_g(t + 1 + 2*k, 1, 1'b0, 8'h50, 8'hC1);
    end
    push_g(t + 9, 0, 1'b0, 8'h51, 8'hC0);
    tick(2);
    set_req(0, 1'b0, 8'h51, 8'hC0);
    tick(8);
    bus.req = '0;
    bus.req_lock = '0;
    tick(2);
`endif

    tick(5);
    check("gnt_queue_drained", 64'(gq.size()), 64'(0));
    check("rvalid_queue_drained", 64'(rq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
